fetch_0: RTL and testbench

PC-generation and instruction-memory request stage of the fetch unit, directly upstream of the second fetch stage. Holds the architectural fetch PC, drives the instruction memory request, and presents `{valid, pc}` as `fetch_1_reg` to the second stage, which pairs it with `inst_in` on `imem_resp`. Advances the PC only when the second stage accepts the response, so a full queue never loses an instruction. Redirects from branch resolution squash in-flight wrong-path responses.

---
 rtl/fetch_0.sv | 102 ++++++++++
 tb/tb_fetch_0.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fetch_0.sv
// fetch_0: fetch PC generation and instruction-memory request stage.
// Presents {valid, pc} to the second fetch stage and squashes wrong-path responses on redirect.
`default_nettype none

module fetch_0 #(
  parameter logic [31:0] RESET_PC = 32'h1ECEB000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_stall,
  input  logic        imem_resp,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic [3:0]  imem_rmask,
  output logic [32:0] fetch_1_reg
);

  localparam logic [1:0] ST_START  = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_SQUASH = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_target;

  logic [1:0]  w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_target_nxt;
  logic [31:0] w_redir_pc;
  logic [31:0] w_newest_target;
  logic        w_valid;

  assign w_redir_pc      = {redirect_pc[31:2], 2'b00};
  assign w_newest_target = redirect_valid ? w_redir_pc : r_target;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_START;
      r_pc     <= RESET_PC;
      r_target <= RESET_PC;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_target <= w_target_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_target_nxt = r_target;
    case (r_state)
      ST_START: begin
        w_state_nxt = ST_REQ;
        if (redirect_valid) w_pc_nxt = w_redir_pc;
      end
      ST_REQ: begin
        if (redirect_valid && imem_resp) begin
          w_pc_nxt = w_redir_pc;
        end else if (redirect_valid) begin
          // The request already issued must complete before the new target is fetched.
          w_target_nxt = w_redir_pc;
          w_state_nxt  = ST_SQUASH;
        end else if (imem_resp && !imem_stall) begin
          w_pc_nxt = r_pc + 32'd4;
        end
      end
      ST_SQUASH: begin
        w_target_nxt = w_newest_target;
        if (imem_resp) begin
          w_pc_nxt    = w_newest_target;
          w_state_nxt = ST_REQ;
        end
      end
      default: w_state_nxt = ST_START;
    endcase
  end

  // Outputs depend only on state, pc and redirect_valid; imem_stall never reaches them.
  always_comb begin
    imem_rmask = 4'h0;
    w_valid    = 1'b0;
    case (r_state)
      ST_REQ: begin
        imem_rmask = 4'hF;
        w_valid    = !redirect_valid;
      end
      ST_SQUASH: imem_rmask = 4'hF;
      default: begin
        imem_rmask = 4'h0;
        w_valid    = 1'b0;
      end
    endcase
  end

  assign imem_addr   = r_pc;
  assign fetch_1_reg = {w_valid, r_pc};

endmodule

`default_nettype wire

// File: tb/tb_fetch_0.sv
// tb_fetch_0: table-driven directed checks for fetch_0 plus a reset-in-SQUASH sequence.
`default_nettype none

module tb_fetch_0;

  logic        clk;
  logic        rst;
  logic        imem_stall;
  logic        imem_resp;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [32:0] fetch_1_reg;

  int checks;
  int passed;

  typedef struct {
    logic        resp;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic [3:0]  rmask;
    logic [31:0] addr;
    logic        valid;
  } vec_t;

  vec_t vecs[21];

  fetch_0 #(.RESET_PC(32'h1ECEB000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_stall     (imem_stall),
    .imem_resp      (imem_resp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rmask     (imem_rmask),
    .fetch_1_reg    (fetch_1_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else
      passed++;
  endtask

  task automatic check_out(input string tag, input logic [3:0] rmask,
                           input logic [31:0] addr, input logic valid);
    check({tag, " rmask"}, {28'd0, imem_rmask}, {28'd0, rmask});
    check({tag, " addr"}, imem_addr, addr);
    check({tag, " valid"}, {31'd0, fetch_1_reg[32]}, {31'd0, valid});
    check({tag, " pc"}, fetch_1_reg[31:0], addr);
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst = 1'b0;
    imem_stall = 1'b0;
    imem_resp = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;

    //          resp  stall rv    rpc           rmask addr          valid
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        4'hF, 32'h1ECEB000, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,        4'hF, 32'h1ECEB004, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,        4'hF, 32'h1ECEB004, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        4'hF, 32'h1ECEB004, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h1ECEB100, 4'hF, 32'h1ECEB008, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        4'hF, 32'h1ECEB008, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        4'hF, 32'h1ECEB008, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h0,        4'hF, 32'h1ECEB008, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        4'hF, 32'h1ECEB100, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h1ECEB200, 4'hF, 32'h1ECEB100, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h1ECEB300, 4'hF, 32'h1ECEB100, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 32'h0,        4'hF, 32'h1ECEB100, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 32'h0,        4'hF, 32'h1ECEB300, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 32'h1ECEB400, 4'hF, 32'h1ECEB304, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h0,        4'hF, 32'h1ECEB400, 1'b1};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 32'h1ECEB500, 4'hF, 32'h1ECEB404, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 32'h1ECEB600, 4'hF, 32'h1ECEB404, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h0,        4'hF, 32'h1ECEB600, 1'b1};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 32'hFFFFFFFC, 4'hF, 32'h1ECEB600, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 32'h0,        4'hF, 32'hFFFFFFFC, 1'b1};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 32'h0,        4'hF, 32'h00000000, 1'b1};

    repeat (2) @(negedge clk);
    #1;
    check_out("reset", 4'h0, 32'h1ECEB000, 1'b0);
    rst = 1'b1;
    #1;
    check_out("start", 4'h0, 32'h1ECEB000, 1'b0);

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      imem_resp      = vecs[i].resp;
      imem_stall     = vecs[i].stall;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].rmask, vecs[i].addr, vecs[i].valid);
    end

    // Enter SQUASH from pc 0, then pull reset while the squashed request is outstanding.
    @(negedge clk);
    imem_resp = 1'b0;
    imem_stall = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h00000C00;
    @(negedge clk);
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    #1;
    check_out("squash", 4'hF, 32'h00000000, 1'b0);
    #1;
    rst = 1'b0;
    #1;
    check_out("async_rst", 4'h0, 32'h1ECEB000, 1'b0);
    imem_resp = 1'b1;
    @(negedge clk);
    #1;
    check_out("rst_held", 4'h0, 32'h1ECEB000, 1'b0);
    imem_resp = 1'b0;
    rst = 1'b1;
    #1;
    check_out("restart", 4'h0, 32'h1ECEB000, 1'b0);
    @(negedge clk);
    #1;
    check_out("first_req", 4'hF, 32'h1ECEB000, 1'b1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
